// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve path: condition codes, FSM states
// and the sequential PC increment. The ALU comparison logic uses the same codes.
package branch_resolve_unit_pkg;

    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_NE  = 3'b011;
    localparam logic [2:0] OP_GEU = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GE  = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam int PC_INC = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

    // Condition codes whose outcome is taken from the comparison result.
    function automatic logic is_cond_op(input logic [2:0] op);
        return (op == OP_EQ) || (op == OP_NE) || (op == OP_GEU) ||
               (op == OP_LTU) || (op == OP_GE);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves execute-stage branches against a static backward-taken prediction,
// issuing a one-cycle redirect and a fixed-length flush on mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic             cmp_result,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_offset,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             illegal_op,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    bru_state_t      state;
    bru_state_t      state_next;
    logic [FC_W-1:0] flush_cnt;

    logic            accept;
    logic            legal_op;
    logic            taken;
    logic            pred_taken;
    logic            mispredict;
    logic [XLEN-1:0] taken_pc;
    logic [XLEN-1:0] fall_pc;

    assign accept   = br_valid && br_ready;
    assign taken_pc = br_pc + br_offset;
    assign fall_pc  = br_pc + XLEN'(PC_INC);

    // Illegal codes resolve as not taken but keep the sign-based prediction.
    always_comb begin
        legal_op   = 1'b1;
        taken      = 1'b0;
        pred_taken = br_offset[XLEN-1];
        if (br_op == OP_JMP) begin
            taken      = 1'b1;
            pred_taken = 1'b1;
        end else if (is_cond_op(br_op)) begin
            taken = cmp_result;
        end else begin
            legal_op = 1'b0;
        end
    end

    assign mispredict = accept && (taken != pred_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mispredict) state_next = FLUSH;
            FLUSH:   if (flush_cnt == FC_ONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        br_ready = (state == IDLE);
        flush    = (state == FLUSH);
    end

    // Counts down the remaining flush cycles; reaches zero as FLUSH exits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if ((state == IDLE) && mispredict) begin
            flush_cnt <= FC_LOAD;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt - FC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_op     <= 1'b0;
        end else begin
            redirect_valid <= mispredict;
            illegal_op     <= accept && !legal_op;
            if (mispredict) begin
                redirect_pc <= taken ? taken_pc : fall_pc;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (accept),
        .count (branch_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (mispredict),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with a response scoreboard and
// hand-written reset-mid-flush and counter saturation sequences.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int XLEN    = 32;
    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int MAX_CNT = (1 << CW) - 1;

    typedef struct {
        logic [2:0]  op;
        logic        cmp;
        logic [31:0] pc;
        logic [31:0] off;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_op;
    logic            cmp_result;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_offset;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            illegal_op;
    logic [CW-1:0]   branch_count;
    logic [CW-1:0]   mispredict_count;

    int          tests = 0;
    int          failed = 0;
    int          flush_left = 0;
    int          exp_bc = 0;
    int          exp_mc = 0;
    logic        exp_ready = 1'b1;
    logic [31:0] last_pc = '0;
    vec_t        exp_q[$];
    vec_t        vecs[$];

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_op            (br_op),
        .cmp_result       (cmp_result),
        .br_pc            (br_pc),
        .br_offset        (br_offset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .illegal_op       (illegal_op),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [2:0] op, input logic cmp,
                                   input logic [31:0] pc, input logic [31:0] off,
                                   input logic redir, input logic [31:0] epc,
                                   input logic ill);
        vec_t v;
        v.op = op; v.cmp = cmp; v.pc = pc; v.off = off;
        v.exp_redir = redir; v.exp_pc = epc; v.exp_ill = ill;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops the pending response (if any) and checks all outputs against the model.
    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkVal("redirect_valid", 32'(redirect_valid), 32'(e.exp_redir));
            checkVal("illegal_op", 32'(illegal_op), 32'(e.exp_ill));
            if (e.exp_redir) begin
                last_pc    = e.exp_pc;
                flush_left = FC;
                if (exp_mc < MAX_CNT) exp_mc++;
            end
            if (exp_bc < MAX_CNT) exp_bc++;
        end else begin
            checkVal("redirect_valid_quiet", 32'(redirect_valid), 32'd0);
            checkVal("illegal_op_quiet", 32'(illegal_op), 32'd0);
        end
        checkVal("redirect_pc", redirect_pc, last_pc);
        checkVal("flush", 32'(flush), 32'(flush_left > 0));
        exp_ready = (flush_left == 0);
        checkVal("br_ready", 32'(br_ready), 32'(exp_ready));
        checkVal("branch_count", 32'(branch_count), 32'(exp_bc));
        checkVal("mispredict_count", 32'(mispredict_count), 32'(exp_mc));
        if (flush_left > 0) flush_left--;
    endtask

    task automatic applyStimulus(input logic v, input vec_t t, output logic accepted);
        br_valid   = v;
        br_op      = t.op;
        cmp_result = t.cmp;
        br_pc      = t.pc;
        br_offset  = t.off;
        accepted   = v && exp_ready && rst_n;
        if (accepted) exp_q.push_back(t);
        @(negedge clk);
        checkOutput();
    endtask

    // Holds a branch on the inputs until the model says it is accepted.
    task automatic sendBranch(input vec_t t);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            applyStimulus(1'b1, t, acc);
            tries++;
        end
        if (!acc) begin
            failed++;
            tests++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 8 cycles");
        end
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        vec_t z;
        z = mkVec(OP_EQ, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, z, acc);
    endtask

    task automatic doReset(input int cycles, input logic v, input vec_t t);
        rst_n      = 1'b0;
        br_valid   = v;
        br_op      = t.op;
        cmp_result = t.cmp;
        br_pc      = t.pc;
        br_offset  = t.off;
        for (int i = 0; i < cycles; i++) @(negedge clk);
        exp_q.delete();
        flush_left = 0;
        exp_bc     = 0;
        exp_mc     = 0;
        last_pc    = '0;
        checkOutput();
        rst_n    = 1'b1;
        br_valid = 1'b0;
    endtask

    initial begin
        vec_t mis;
        vec_t s;
        logic [31:0] pc;

        vecs.push_back(mkVec(OP_EQ,  1'b1, 32'h0000_1000, 32'h0000_0020, 1'b1, 32'h0000_1020, 1'b0));
        vecs.push_back(mkVec(OP_NE,  1'b1, 32'h0000_2000, 32'hFFFF_FFF0, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mkVec(OP_LTU, 1'b0, 32'h0000_2100, 32'h0000_0040, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mkVec(OP_GEU, 1'b0, 32'h0000_3000, 32'hFFFF_FF00, 1'b1, 32'h0000_3004, 1'b0));
        vecs.push_back(mkVec(OP_JMP, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mkVec(OP_EQ,  1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0));
        vecs.push_back(mkVec(3'b010, 1'b1, 32'h0000_4000, 32'h0000_0010, 1'b0, 32'h0,         1'b1));
        vecs.push_back(mkVec(3'b000, 1'b1, 32'h0000_5000, 32'hFFFF_FFFC, 1'b1, 32'h0000_5004, 1'b1));
        vecs.push_back(mkVec(OP_GE,  1'b1, 32'h0000_6000, 32'h0000_0100, 1'b1, 32'h0000_6100, 1'b0));
        vecs.push_back(mkVec(OP_GE,  1'b0, 32'h0000_6000, 32'hFFFF_FF80, 1'b1, 32'h0000_6004, 1'b0));
        vecs.push_back(mkVec(OP_JMP, 1'b0, 32'h0000_7000, 32'h0000_0010, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mkVec(OP_EQ,  1'b0, 32'h0000_8000, 32'h0000_0010, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mkVec(OP_NE,  1'b0, 32'h0000_9000, 32'hFFFF_FFE0, 1'b1, 32'h0000_9004, 1'b0));

        mis = mkVec(OP_EQ, 1'b1, 32'h0000_A000, 32'h0000_0040, 1'b1, 32'h0000_A040, 1'b0);

        doReset(2, 1'b1, mis);

        foreach (vecs[i]) sendBranch(vecs[i]);
        idleCycles(3);

        // Reset lands on the first FLUSH cycle with a branch still presented.
        sendBranch(mis);
        doReset(1, 1'b1, mis);
        idleCycles(2);

        for (int i = 0; i < 20; i++) begin
            pc = 32'h0001_0000 + 32'(i) * 32'h10;
            s  = mkVec(OP_EQ, 1'b1, pc, 32'h0000_0040, 1'b1, pc + 32'h40, 1'b0);
            sendBranch(s);
        end
        idleCycles(3);
        checkVal("branch_count_saturated", 32'(branch_count), 32'(MAX_CNT));
        checkVal("mispredict_count_saturated", 32'(mispredict_count), 32'(MAX_CNT));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
